// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid memory port between instruction fetch and data.
// An in-order ID FIFO routes each memory response back to the channel that issued it.
module core_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  instr_req_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,

  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic [DATA_WIDTH-1:0] data_rdata_o,

  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,

  output logic                  protocol_err_o
);

  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUTSTANDING - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(MAX_OUTSTANDING);

  localparam logic ChInstr = 1'b0;
  localparam logic ChData  = 1'b1;

  typedef enum logic [1:0] {StIdle, StLockI, StLockD} lock_e;

  lock_e                      lock_q, lock_d;
  logic                       rr_last_q, rr_last_d;
  logic [MAX_OUTSTANDING-1:0] id_q, id_d;
  logic [PtrW-1:0]            wptr_q, wptr_d;
  logic [PtrW-1:0]            rptr_q, rptr_d;
  logic [CntW-1:0]            count_q, count_d;
  logic                       err_q, err_d;

  logic sel;
  logic sel_req;
  logic full;
  logic handshake;
  logic pop;
  logic head_id;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  // Selection: a locked channel keeps the port until granted, otherwise round-robin.
  always_comb begin
    sel = ChData;
    case (lock_q)
      StLockI: sel = ChInstr;
      StLockD: sel = ChData;
      default: begin
        if (instr_req_i && !data_req_i)      sel = ChInstr;
        else if (data_req_i && !instr_req_i) sel = ChData;
        else                                 sel = ~rr_last_q;
      end
    endcase
  end

  assign sel_req   = sel ? data_req_i : instr_req_i;
  assign full      = (count_q == CntFull);
  assign mem_req_o = rst_ni & ~full & sel_req;
  assign handshake = mem_req_o & mem_gnt_i;

  assign instr_gnt_o = handshake & ~sel;
  assign data_gnt_o  = handshake & sel;

  assign mem_addr_o  = sel ? data_addr_i : instr_addr_i;
  assign mem_we_o    = sel & data_we_i;
  assign mem_be_o    = sel ? data_be_i : 4'hF;
  assign mem_wdata_o = sel ? data_wdata_i : '0;

  // Responses return in issue order; an rvalid with nothing outstanding is dropped and flagged.
  assign pop     = mem_rvalid_i & (count_q != '0);
  assign head_id = id_q[rptr_q];

  assign instr_rvalid_o = rst_ni & pop & ~head_id;
  assign data_rvalid_o  = rst_ni & pop & head_id;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  assign protocol_err_o = err_q;

  always_comb begin
    lock_d    = lock_q;
    rr_last_d = rr_last_q;
    id_d      = id_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    err_d     = err_q;

    case (lock_q)
      StIdle: begin
        if (mem_req_o && !mem_gnt_i) lock_d = sel ? StLockD : StLockI;
      end
      default: begin
        // A withdrawn request also releases the lock.
        if (handshake || !sel_req) lock_d = StIdle;
      end
    endcase

    if (handshake) begin
      id_d[wptr_q] = sel;
      wptr_d       = ptr_inc(wptr_q);
      rr_last_d    = sel;
    end

    if (pop) rptr_d = ptr_inc(rptr_q);

    case ({handshake, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (mem_rvalid_i && (count_q == '0)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q    <= StIdle;
      rr_last_q <= ChInstr;
      id_q      <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      rr_last_q <= rr_last_d;
      id_q      <= id_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: a one-cycle-latency memory model plus a
// scoreboard of expected (channel, data) responses pushed at grant and popped at rvalid.
module tb_core_mem_arbiter;

  logic        clk_i;
  logic        rst_ni;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic [3:0]  data_be_i;
  logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;
  logic        protocol_err_o;

  core_mem_arbiter #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .instr_req_i    (instr_req_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_addr_i   (instr_addr_i),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_addr_i    (data_addr_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_wdata_i   (data_wdata_i),
    .data_rdata_o   (data_rdata_o),
    .mem_req_o      (mem_req_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_addr_o     (mem_addr_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i),
    .protocol_err_o (protocol_err_o)
  );

  typedef struct packed {
    logic        chan;  // 0: instr, 1: data
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_pend[$];
  logic        resp_en;
  int          n_checks;
  int          n_errors;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'h3C3C, ~a[15:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Sample at the falling edge: memory model captures accepted requests, scoreboard
  // records grants and checks any response against the oldest expectation.
  task automatic observe();
    exp_t e;
    @(negedge clk_i);
    if (mem_req_o && mem_gnt_i) mem_pend.push_back(mem_model(mem_addr_o));
    if (instr_gnt_o) sb.push_back('{chan: 1'b0, data: mem_model(instr_addr_i)});
    if (data_gnt_o)  sb.push_back('{chan: 1'b1, data: mem_model(data_addr_i)});
    if (instr_rvalid_o || data_rvalid_o) begin
      if (sb.size() == 0) begin
        check_eq("rsp_unexpected", {62'd0, instr_rvalid_o, data_rvalid_o}, 64'd0);
      end else begin
        e = sb.pop_front();
        check_eq("rsp_route", {62'd0, instr_rvalid_o, data_rvalid_o},
                 e.chan ? 64'd1 : 64'd2);
        check_eq("rsp_data", instr_rvalid_o ? instr_rdata_o : data_rdata_o, e.data);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (resp_en && mem_pend.size() > 0) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_pend.pop_front();
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h5A5A_5A5A;
    end
  endtask

  task automatic drain();
    instr_req_i = 1'b0;
    data_req_i  = 1'b0;
    data_we_i   = 1'b0;
    resp_en     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0 && mem_pend.size() == 0) break;
      observe();
      tick();
    end
    check_eq("drain_empty", sb.size(), 0);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    resp_en      = 1'b1;
    rst_ni       = 1'b0;
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0;
    data_req_i   = 1'b1;
    data_addr_i  = 32'h0;
    data_we_i    = 1'b0;
    data_be_i    = 4'hF;
    data_wdata_i = 32'h0;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0;

    // Reset: outputs held low even with requests and rvalid active.
    #1;
    check_eq("rst_mem_req", mem_req_o, 0);
    check_eq("rst_gnts", {instr_gnt_o, data_gnt_o}, 0);
    check_eq("rst_rvalids", {instr_rvalid_o, data_rvalid_o}, 0);
    check_eq("rst_err", protocol_err_o, 0);
    repeat (2) @(posedge clk_i);
    #1;
    instr_req_i  = 1'b0;
    data_req_i   = 1'b0;
    mem_rvalid_i = 1'b0;
    rst_ni       = 1'b1;

    // Single instruction fetch, granted same cycle, response next cycle.
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h100;
    data_wdata_i = 32'h1234_5678;
    observe();
    check_eq("t1_instr_gnt", instr_gnt_o, 1);
    check_eq("t1_data_gnt", data_gnt_o, 0);
    check_eq("t1_mem_addr", mem_addr_o, 32'h100);
    check_eq("t1_mem_we", mem_we_o, 0);
    check_eq("t1_mem_be", mem_be_o, 4'hF);
    check_eq("t1_mem_wdata", mem_wdata_o, 0);
    tick();
    instr_req_i = 1'b0;
    observe();
    check_eq("t1_instr_rvalid", instr_rvalid_o, 1);
    check_eq("t1_data_rvalid", data_rvalid_o, 0);
    check_eq("t1_instr_rdata", instr_rdata_o, 32'hDEADBEEF);
    tick();
    check_eq("t1_err", protocol_err_o, 0);

    // Both channels request continuously: grants alternate starting with data.
    for (int i = 0; i < 5; i++) begin
      instr_req_i  = 1'b1;
      data_req_i   = 1'b1;
      instr_addr_i = 32'h1000 + 32'(4 * i);
      data_addr_i  = 32'h2000 + 32'(4 * i);
      observe();
      check_eq($sformatf("t2_gnt%0d", i), {instr_gnt_o, data_gnt_o},
               (i % 2 == 0) ? 64'd1 : 64'd2);
      tick();
    end
    drain();

    // Stalled data write must hold the port against a competing fetch.
    for (int i = 0; i < 4; i++) begin
      instr_req_i  = (i > 0);
      instr_addr_i = 32'h300;
      data_req_i   = 1'b1;
      data_we_i    = 1'b1;
      data_addr_i  = 32'h200;
      data_wdata_i = 32'hCAFEF00D;
      data_be_i    = 4'h3;
      mem_gnt_i    = (i == 3);
      observe();
      check_eq($sformatf("t3_req%0d", i), mem_req_o, 1);
      check_eq($sformatf("t3_addr%0d", i), mem_addr_o, 32'h200);
      check_eq($sformatf("t3_wdata%0d", i), mem_wdata_o, 32'hCAFEF00D);
      check_eq($sformatf("t3_be_we%0d", i), {mem_be_o, mem_we_o}, {4'h3, 1'b1});
      check_eq($sformatf("t3_gnts%0d", i), {instr_gnt_o, data_gnt_o}, (i == 3) ? 64'd1 : 64'd0);
      tick();
    end
    data_we_i   = 1'b0;
    data_addr_i = 32'h204;
    observe();
    check_eq("t3_rr_after_lock", {instr_gnt_o, data_gnt_o}, 2'b10);
    tick();
    drain();

    // Two outstanding with no responses: port blocked until a slot frees.
    resp_en      = 1'b0;
    mem_gnt_i    = 1'b1;
    instr_req_i  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      instr_addr_i = 32'h400 + 32'(4 * i);
      observe();
      check_eq($sformatf("t4_fill_gnt%0d", i), instr_gnt_o, 1);
      tick();
    end
    instr_addr_i = 32'h408;
    observe();
    check_eq("t4_full_req", mem_req_o, 0);
    check_eq("t4_full_gnt", {instr_gnt_o, data_gnt_o}, 0);
    resp_en = 1'b1;
    tick();
    observe();
    check_eq("t4_pop_no_bypass", mem_req_o, 0);
    check_eq("t4_pop_rvalid", instr_rvalid_o, 1);
    tick();
    observe();
    check_eq("t4_req_again", mem_req_o, 1);
    check_eq("t4_gnt_again", instr_gnt_o, 1);
    tick();
    drain();

    // Response with nothing outstanding: flagged, sticky, cleared by reset.
    resp_en      = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1111_2222;
    observe();
    check_eq("t5_no_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
    tick();
    observe();
    check_eq("t5_err_set", protocol_err_o, 1);
    tick();
    observe();
    check_eq("t5_err_held", protocol_err_o, 1);
    rst_ni = 1'b0;
    #1;
    check_eq("t5_err_cleared", protocol_err_o, 0);
    tick();
    rst_ni = 1'b1;

    // Reset with two outstanding, then a fresh fetch completes normally.
    instr_req_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      instr_addr_i = 32'h500 + 32'(4 * i);
      observe();
      check_eq($sformatf("t6_fill_gnt%0d", i), instr_gnt_o, 1);
      tick();
    end
    data_req_i = 1'b1;
    rst_ni     = 1'b0;
    #1;
    check_eq("t6_rst_req", mem_req_o, 0);
    check_eq("t6_rst_gnts", {instr_gnt_o, data_gnt_o}, 0);
    check_eq("t6_rst_rvalids", {instr_rvalid_o, data_rvalid_o}, 0);
    sb.delete();
    mem_pend.delete();
    tick();
    rst_ni       = 1'b1;
    data_req_i   = 1'b0;
    resp_en      = 1'b1;
    instr_addr_i = 32'h100;
    observe();
    check_eq("t6_fetch_gnt", instr_gnt_o, 1);
    tick();
    instr_req_i = 1'b0;
    observe();
    check_eq("t6_fetch_rvalid", instr_rvalid_o, 1);
    check_eq("t6_fetch_rdata", instr_rdata_o, 32'hDEADBEEF);
    check_eq("t6_err", protocol_err_o, 0);
    tick();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
